// File: rtl/branch_cmp_32.sv
// RV32I branch comparator: evaluates one of six branch conditions on rs1/rs2,
// with a combinational taken result and a registered copy plus valid pulse.
module branch_cmp_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctrl,
    output logic             c,
    output logic             eq,
    output logic             lt,
    output logic             ltu,
    output logic             c_q,
    output logic             valid_q
);

    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [2:0] CTRL_NONE = 3'b000;
    localparam logic [2:0] CTRL_EQ   = 3'b001;
    localparam logic [2:0] CTRL_NE   = 3'b010;
    localparam logic [2:0] CTRL_LT   = 3'b011;
    localparam logic [2:0] CTRL_LTU  = 3'b100;
    localparam logic [2:0] CTRL_GE   = 3'b101;
    localparam logic [2:0] CTRL_GEU  = 3'b110;

    // Signed order differs from unsigned only when the sign bits disagree;
    // then the negative operand (bit MSB set) is the smaller one.
    assign eq  = (a == b);
    assign ltu = (a < b);
    assign lt  = (a[MSB] ^ b[MSB]) ? a[MSB] : ltu;

    // Condition select; none and reserved codes report not-taken.
    always_comb begin
        c = 1'b0;
        case (ctrl)
            CTRL_NONE: c = 1'b0;
            CTRL_EQ:   c = eq;
            CTRL_NE:   c = ~eq;
            CTRL_LT:   c = lt;
            CTRL_LTU:  c = ltu;
            CTRL_GE:   c = ~lt;
            CTRL_GEU:  c = ~ltu;
            default:   c = 1'b0;
        endcase
    end

    // Captured result for pipelined consumers; reset takes priority over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q     <= 1'b0;
            valid_q <= 1'b0;
        end else if (en) begin
            c_q     <= c;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_cmp_32.sv
// Bench for branch_cmp_32: directed corner cases plus randomized traffic
// checked against an integer-arithmetic reference model.
module tb_branch_cmp_32;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic        c;
    logic        eq;
    logic        lt;
    logic        ltu;
    logic        c_q;
    logic        valid_q;

    int n_cmp;
    int n_err;

    branch_cmp_32 #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .a       (a),
        .b       (b),
        .ctrl    (ctrl),
        .c       (c),
        .eq      (eq),
        .lt      (lt),
        .ltu     (ltu),
        .c_q     (c_q),
        .valid_q (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: operands as mathematical integers, signed via two's complement value.
    function automatic longint sval(input logic [31:0] x);
        return x[31] ? (longint'(x) - 64'sd4294967296) : longint'(x);
    endfunction

    function automatic logic ref_c(input logic [31:0] x, input logic [31:0] y,
                                   input logic [2:0] sel);
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = sval(x);
        longint sy = sval(y);
        case (sel)
            3'd1:    return ux == uy;
            3'd2:    return ux != uy;
            3'd3:    return sx < sy;
            3'd4:    return ux < uy;
            3'd5:    return sx >= sy;
            3'd6:    return ux >= uy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic [2:0] sel);
        @(negedge clk);
        a = x;
        b = y;
        ctrl = sel;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (c_q !== 1'b0 || valid_q !== 1'b0) begin
            n_err++;
            $display("FAIL reset: c_q=%b valid_q=%b expected 0/0", c_q, valid_q);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_equal();
        logic [2:0] sels [4] = '{3'b001, 3'b010, 3'b101, 3'b110};
        logic       exps [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            apply(32'h1234_5678, 32'h1234_5678, sels[i]);
            n_cmp++;
            if (c !== exps[i]) begin
                n_err++;
                $display("FAIL equal ctrl=%b: c=%b expected %b", sels[i], c, exps[i]);
            end
        end
        n_cmp++;
        if (eq !== 1'b1 || lt !== 1'b0 || ltu !== 1'b0) begin
            n_err++;
            $display("FAIL equal flags: eq/lt/ltu=%b%b%b expected 100", eq, lt, ltu);
        end
    endtask

    task automatic test_sign_boundary();
        logic [2:0] sels [4] = '{3'b011, 3'b100, 3'b101, 3'b110};
        logic       exps [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            apply(32'h8000_0000, 32'h0000_0001, sels[i]);
            n_cmp++;
            if (c !== exps[i]) begin
                n_err++;
                $display("FAIL sign_boundary ctrl=%b: c=%b expected %b", sels[i], c, exps[i]);
            end
        end
    endtask

    task automatic test_extremes();
        logic [2:0] sels [5] = '{3'b011, 3'b100, 3'b101, 3'b110, 3'b010};
        logic       exps [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            apply(32'hFFFF_FFFF, 32'h0000_0000, sels[i]);
            n_cmp++;
            if (c !== exps[i]) begin
                n_err++;
                $display("FAIL extremes ctrl=%b: c=%b expected %b", sels[i], c, exps[i]);
            end
        end
        apply(32'h0000_0000, 32'hFFFF_FFFF, 3'b011);
        n_cmp++;
        if (c !== 1'b0 || lt !== 1'b0 || ltu !== 1'b1) begin
            n_err++;
            $display("FAIL extremes_swap: c/lt/ltu=%b%b%b expected 001", c, lt, ltu);
        end
        apply(32'h0000_0000, 32'hFFFF_FFFF, 3'b100);
        n_cmp++;
        if (c !== 1'b1) begin
            n_err++;
            $display("FAIL extremes_swap_ltu: c=%b expected 1", c);
        end
    endtask

    task automatic test_reserved();
        logic [2:0]  sels [2] = '{3'b000, 3'b111};
        logic [31:0] bs   [2] = '{32'hDEAD_BEEF, 32'h0000_0042};
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                apply(32'hDEAD_BEEF, bs[j], sels[i]);
                n_cmp++;
                if (c !== 1'b0) begin
                    n_err++;
                    $display("FAIL reserved ctrl=%b b=%h: c=%b expected 0", sels[i], bs[j], c);
                end
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        rst = 1'b0; en = 1'b1; a = 32'd5; b = 32'd7; ctrl = 3'b011;
        @(posedge clk); #1;
        n_cmp++;
        if (c_q !== 1'b1 || valid_q !== 1'b1) begin
            n_err++;
            $display("FAIL reg_capture: c_q=%b valid_q=%b expected 1/1", c_q, valid_q);
        end
        @(negedge clk);
        en = 1'b0; a = 32'd9; b = 32'd1;
        @(posedge clk); #1;
        n_cmp++;
        if (c_q !== 1'b1 || valid_q !== 1'b0) begin
            n_err++;
            $display("FAIL reg_hold: c_q=%b valid_q=%b expected 1/0", c_q, valid_q);
        end
        @(negedge clk);
        rst = 1'b1; en = 1'b1; a = 32'd5; b = 32'd7; ctrl = 3'b011;
        @(posedge clk); #1;
        n_cmp++;
        if (c_q !== 1'b0 || valid_q !== 1'b0) begin
            n_err++;
            $display("FAIL reg_rst_wins: c_q=%b valid_q=%b expected 0/0", c_q, valid_q);
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b1; a = 32'd1; b = 32'd2; ctrl = 3'b111;
        @(posedge clk); #1;
        n_cmp++;
        if (c_q !== 1'b0 || valid_q !== 1'b1) begin
            n_err++;
            $display("FAIL reg_reserved: c_q=%b valid_q=%b expected 0/1", c_q, valid_q);
        end
    endtask

    task automatic test_random();
        logic [31:0] corners [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000,
                                    32'hFFFF_FFFF, 32'h8000_0001};
        logic exp_cq = 1'b0;
        logic exp_v  = 1'b0;
        int   bad_comb = 0;
        int   bad_reg  = 0;
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            logic [2:0]  s;
            logic        r;
            logic        e;
            logic        rc;
            x = $urandom();
            y = $urandom();
            case ($urandom_range(0, 7))
                0: y = x;
                1: x = corners[$urandom_range(0, 5)];
                2: y = corners[$urandom_range(0, 5)];
                3: y = x ^ (32'h1 << $urandom_range(0, 31));
                default: ;
            endcase
            s = 3'($urandom_range(0, 7));
            r = ($urandom_range(0, 63) == 0);
            e = 1'($urandom_range(0, 1));
            @(negedge clk);
            a = x; b = y; ctrl = s; rst = r; en = e;
            #1;
            rc = ref_c(x, y, s);
            n_cmp++;
            if (c !== rc || eq !== (x == y) || lt !== (sval(x) < sval(y))
                || ltu !== (longint'(x) < longint'(y))) begin
                n_err++;
                if (bad_comb++ < 10)
                    $display("FAIL random_comb a=%h b=%h ctrl=%b: c/eq/lt/ltu=%b%b%b%b expected %b%b%b%b",
                             x, y, s, c, eq, lt, ltu, rc, x == y, sval(x) < sval(y),
                             longint'(x) < longint'(y));
            end
            if (r) begin
                exp_cq = 1'b0; exp_v = 1'b0;
            end else if (e) begin
                exp_cq = rc; exp_v = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
            @(posedge clk); #1;
            n_cmp++;
            if (c_q !== exp_cq || valid_q !== exp_v) begin
                n_err++;
                if (bad_reg++ < 10)
                    $display("FAIL random_reg iter=%0d: c_q=%b valid_q=%b expected %b/%b",
                             i, c_q, valid_q, exp_cq, exp_v);
            end
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        en = 1'b0;
        a = '0;
        b = '0;
        ctrl = 3'b000;
        test_reset();
        test_equal();
        test_sign_boundary();
        test_extremes();
        test_reserved();
        test_registered();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_cmp_32.md
Name: branch_cmp_32

Overview:
- 32-bit branch comparator for the RV32I jump/branch functional unit.
- Evaluates one of six RISC-V branch conditions on two operands and drives a 1-bit taken result.
- The combinational result `c` feeds the jump unit directly from its latched operands.
- A registered copy with a valid flag serves pipelined consumers.

Parameters:
- WIDTH, 32, operand width. Only 32 is required to be supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  capture strobe; registers a/b/ctrl result at the next rising edge.
- a  input  32  first operand (rs1).
- b  input  32  second operand (rs2).
- ctrl  input  3  condition select (encoding below).
- c  output  1  combinational compare result for current a, b, ctrl.
- eq  output  1  combinational, a == b.
- lt  output  1  combinational, signed a < b.
- ltu  output  1  combinational, unsigned a < b.
- c_q  output  1  registered c.
- valid_q  output  1  c_q holds a result captured on the previous edge.

Behaviour:
- ctrl encoding:
  - 3'b000: none, c=0.
  - 3'b001: EQ, c = a==b.
  - 3'b010: NE, c = a!=b.
  - 3'b011: LT (signed), c = $signed(a) < $signed(b).
  - 3'b100: LTU (unsigned), c = a < b.
  - 3'b101: GE (signed), c = !(signed a < b).
  - 3'b110: GEU (unsigned), c = !(a < b).
  - 3'b111: reserved, c=0.
- c, eq, lt, ltu are purely combinational from a, b, ctrl: zero latency, no dependence on clk/rst/en.
- Signed compare is two's complement over the full 32 bits:
  - operands with different bit 31: the one with bit31=1 is smaller;
  - otherwise decided by the unsigned compare.
- Unsigned compare is a 32-bit magnitude compare; a subtract-and-borrow or tree structure is acceptable, but results must be exact for all 2^64 operand pairs.
- Registered path, at each rising clk:
  - if rst: c_q<=0, valid_q<=0;
  - else if en: c_q<=c, valid_q<=1;
  - else: c_q holds its value, valid_q<=0.
- Latency: c_q/valid_q reflect inputs sampled one cycle earlier. valid_q is a single-cycle pulse per en cycle, high continuously for back-to-back en.
- rst and en together: rst wins.
- Power-up before the first reset: c_q and valid_q are undefined. The consumer must apply rst.
- Reserved/none ctrl with en=1: c_q<=0, valid_q<=1. This is a valid "not taken" result.
- a==b: eq=1, lt=0, ltu=0; GE and GEU both give 1.
- No X propagation requirement beyond standard RTL semantics.

Test Plan:
- Equal operands: a=b=32'h1234_5678.
  - ctrl=001 -> c=1; ctrl=010 -> c=0; ctrl=101 -> c=1; ctrl=110 -> c=1.
  - eq=1, lt=0, ltu=0.
- Sign boundary: a=32'h8000_0000, b=32'h0000_0001.
  - ctrl=011 -> c=1; ctrl=100 -> c=0; ctrl=101 -> c=0; ctrl=110 -> c=1.
- Extremes: a=32'hFFFF_FFFF (-1), b=32'h0000_0000.
  - LT=1, LTU=0, GE=0, GEU=1, NE=1.
  - Swap operands -> LT=0, LTU=1.
- Reserved codes: any a, b with ctrl=000 and ctrl=111 -> c=0 (check with a=b and with a≠b).
- Registered path:
  - rst=1 for 2 cycles -> c_q=0, valid_q=0.
  - en=1 with a=5, b=7, ctrl=011 -> next cycle c_q=1, valid_q=1.
  - en=0 next cycle -> c_q stays 1, valid_q=0.
  - rst=1 with en=1 -> c_q=0, valid_q=0.
- Randomized: 10k random a/b/ctrl -> c, eq, lt, ltu match a signed/unsigned reference model. c_q matches c delayed one cycle whenever en was high.
